module_alu_arbiter: RTL and testbench
=====================================

Name: module_alu_arbiter

Overview:
Shares the single ALU datapath (operation units plus the 16:1 result mux selected by a 4-bit ALUControl) between two requesters.
- Each requester submits an operation with a valid/ready handshake: operand A, operand B and a 4-bit opcode.
- The arbiter grants round-robin, registers the operands and opcode, and holds them stable on the ALU inputs for the ALU latency.
- It captures the ALU result and returns it, tagged with the requester id, through a valid/ready response channel.
- It sits between the instruction-side sources and the ALU top.

Parameters:
ALU_LAT, 1, cycles from stable ALU inputs to valid alu_result_i (legal range 1..15).
CNT_W, 16, width of the completed-operation counter.

Ports:
clk_i  input  1  system clock, rising edge.
rst_n_i  input  1  reset, asynchronous, active-low.
req0_valid_i  input  1  requester 0 has an operation.
req0_ready_o  output  1  requester 0 operation accepted this cycle.
req0_a_i  input  pkg_bits::bitsw_t  requester 0 operand A.
req0_b_i  input  pkg_bits::bitsw_t  requester 0 operand B.
req0_op_i  input  4  requester 0 ALUControl code.
req1_valid_i / req1_ready_o / req1_a_i / req1_b_i / req1_op_i  (same as requester 0, for requester 1).
alu_a_o  output  pkg_bits::bitsw_t  operand A to ALU.
alu_b_o  output  pkg_bits::bitsw_t  operand B to ALU.
alu_ctrl_o  output  4  ALUControl to the result mux.
alu_result_i  input  pkg_bits::bitsw_t  ALU result.
rsp_valid_o  output  1  response available.
rsp_ready_i  input  1  consumer takes the response.
rsp_id_o  output  1  id of the requester that owns the response.
rsp_result_o  output  pkg_bits::bitsw_t  registered ALU result.
busy_o  output  1  high in any state other than IDLE.
op_cnt_o  output  CNT_W  count of completed responses.

Behaviour:
- One clock domain. Reset is asynchronous, active-low. While rst_n_i=0, all outputs are 0, state=IDLE and last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The grant is combinational.
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready_o = (state==IDLE) & grantN. At most one ready is high per cycle.
  - On a valid&ready edge: register a, b, op into alu_a_o, alu_b_o, alu_ctrl_o; register id; load lat_cnt=ALU_LAT; go to EXEC.
- EXEC:
  - alu_a_o, alu_b_o and alu_ctrl_o are held stable.
  - lat_cnt decrements each cycle.
  - On the edge where lat_cnt==1: rsp_result_o <= alu_result_i; go to RESP.
- RESP:
  - rsp_valid_o=1. rsp_result_o and rsp_id_o are held stable.
  - On rsp_valid_o & rsp_ready_i: last_grant <= rsp_id_o; op_cnt_o increments (wraps at 2^CNT_W-1 -> 0); go to IDLE.
- Latency:
  - Accept edge at cycle t. rsp_valid_o is high from cycle t+ALU_LAT+1.
  - rsp_ready_i already high gives a one-cycle RESP.
  - Maximum throughput is one operation per ALU_LAT+2 cycles.
- No accept occurs during EXEC or RESP: both readies are 0, and requesters hold valid and data until ready.
- Backpressure: rsp_ready_i low holds RESP indefinitely. Requests queue on their valid lines without loss.
- All 16 opcodes pass through unmodified. The arbiter does not interpret them.
- A valid that drops before ready is a protocol violation. It is not checked.
- Reset asserted mid-operation: the in-flight operation is discarded and no response is produced. op_cnt_o clears to 0.
- alu_* outputs keep their last values in IDLE. They are not zeroed.

Decomposition:
- pkg_bits: existing bitsw_t, plus alu_op_t (logic [3:0]), an arb_state_t enum {IDLE, EXEC, RESP}, and ALU_LAT_DEF=1.
- Sub-module module_rr_arbiter2: combinational two-requester round-robin grant from valid0, valid1 and last_grant.
- The FSM, registers and counters stay in module_alu_arbiter.

Test Plan:
- Reset with ALU_LAT=1:
  - Stimulus: req0 valid, A=5, B=3, op=0; ALU model returns A+B.
  - Required: req0_ready_o high in the first cycle; rsp_valid_o 2 cycles later with rsp_result_o=8, rsp_id_o=0; op_cnt_o=1 after the handshake.
- Tie: both requests valid continuously.
  - Required: grants alternate 0,1,0,1 over four operations; rsp_id_o sequence 0,1,0,1.
- Backpressure: rsp_ready_i=0 for 5 cycles during RESP.
  - Required: rsp_valid_o, rsp_result_o and rsp_id_o stay stable; req readies stay 0; one completion counted on release.
- ALU_LAT=3: req1 op=4'hF.
  - Required: alu_ctrl_o=F held for 3 cycles; rsp_valid_o at accept+4.
- Reset pulse in EXEC.
  - Required: all outputs 0 immediately (async); no rsp_valid_o afterwards; requester 0 wins the next tie.
- Counter wrap: with CNT_W=4, run 17 operations.
  - Required: op_cnt_o=1.

Source files
------------

// File: rtl/module_alu_arbiter_pkg.sv
// Shared ALU datapath types: operand word, opcode and arbiter FSM states.
// Pure type/constant package; no logic, no latency.
// No flow control of its own.
package pkg_bits;
    localparam int BITS_W      = 32;
    localparam int ALU_LAT_DEF = 1;

    typedef logic [BITS_W-1:0] bitsw_t;
    typedef logic [3:0]        alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;
endpackage

// File: rtl/module_alu_arbiter_rr.sv
// Two-requester round-robin grant; on a tie the side that did not win last time wins.
// Combinational, zero latency.
// Grants are advisory; the caller qualifies them with its own ready condition.
module module_rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);
    always_comb begin
        grant0 = valid0 & (~valid1 | last_grant);
        grant1 = valid1 & (~valid0 | ~last_grant);
    end
endmodule

// File: rtl/module_alu_arbiter.sv
// Shares one ALU between two valid/ready requesters and returns id-tagged results.
// Accept to rsp_valid_o is ALU_LAT+1 cycles; one operation in flight at a time.
// Both readies stay low until the response is taken; rsp_ready_i low holds RESP.
module module_alu_arbiter
    import pkg_bits::*;
#(
    parameter int ALU_LAT = ALU_LAT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  bitsw_t           req0_a_i,
    input  bitsw_t           req0_b_i,
    input  alu_op_t          req0_op_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  bitsw_t           req1_a_i,
    input  bitsw_t           req1_b_i,
    input  alu_op_t          req1_op_i,
    output bitsw_t           alu_a_o,
    output bitsw_t           alu_b_o,
    output alu_op_t          alu_ctrl_o,
    input  bitsw_t           alu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output bitsw_t           rsp_result_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] op_cnt_o
);
    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

    arb_state_t state, state_nxt;
    logic       grant0, grant1, last_grant;
    logic       fire0, fire1;
    logic [3:0] lat_cnt;

    module_rr_arbiter2 u_rr (
        .valid0     (req0_valid_i),
        .valid1     (req1_valid_i),
        .last_grant (last_grant),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    // Readies are gated by reset so every output reads 0 while rst_n_i is low.
    assign req0_ready_o = rst_n_i & (state == IDLE) & grant0;
    assign req1_ready_o = rst_n_i & (state == IDLE) & grant1;
    assign fire0        = req0_valid_i & req0_ready_o;
    assign fire1        = req1_valid_i & req1_ready_o;
    assign rsp_valid_o  = (state == RESP);
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fire0 | fire1)      state_nxt = EXEC;
            EXEC:    if (lat_cnt == 4'd1)    state_nxt = RESP;
            RESP:    if (rsp_ready_i)        state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            alu_a_o      <= '0;
            alu_b_o      <= '0;
            alu_ctrl_o   <= '0;
            rsp_id_o     <= 1'b0;
            rsp_result_o <= '0;
            lat_cnt      <= '0;
            last_grant   <= 1'b1;
            op_cnt_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire0 | fire1) begin
                        alu_a_o    <= fire1 ? req1_a_i  : req0_a_i;
                        alu_b_o    <= fire1 ? req1_b_i  : req0_b_i;
                        alu_ctrl_o <= fire1 ? req1_op_i : req0_op_i;
                        rsp_id_o   <= fire1;
                        lat_cnt    <= LAT_INIT;
                    end
                end
                EXEC: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) rsp_result_o <= alu_result_i;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        last_grant <= rsp_id_o;
                        op_cnt_o   <= op_cnt_o + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_module_alu_arbiter.sv
// Directed bench: main instance (ALU_LAT=1), a 4-bit-counter twin on the same inputs,
// and an ALU_LAT=3 instance with its own requesters.
module tb_module_alu_arbiter;
    import pkg_bits::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic    rst_n;
    logic    req0_valid, req1_valid, rsp_ready;
    bitsw_t  req0_a, req0_b, req1_a, req1_b;
    alu_op_t req0_op, req1_op;

    logic        m_rdy0, m_rdy1, m_rsp_valid, m_rsp_id, m_busy;
    bitsw_t      m_alu_a, m_alu_b, m_alu_res, m_rsp_res;
    alu_op_t     m_alu_ctrl;
    logic [15:0] m_cnt;

    logic        w_rdy0, w_rdy1, w_rsp_valid, w_rsp_id, w_busy;
    bitsw_t      w_alu_a, w_alu_b, w_alu_res, w_rsp_res;
    alu_op_t     w_alu_ctrl;
    logic [3:0]  w_cnt;

    logic        t_req0_valid, t_req1_valid, t_rsp_ready;
    bitsw_t      t_req0_a, t_req0_b, t_req1_a, t_req1_b;
    alu_op_t     t_req0_op, t_req1_op;
    logic        t_rdy0, t_rdy1, t_rsp_valid, t_rsp_id, t_busy;
    bitsw_t      t_alu_a, t_alu_b, t_alu_res, t_rsp_res;
    alu_op_t     t_alu_ctrl;
    logic [15:0] t_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic bitsw_t alu_f(bitsw_t a, bitsw_t b, alu_op_t op);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'hF:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    assign m_alu_res = alu_f(m_alu_a, m_alu_b, m_alu_ctrl);
    assign w_alu_res = alu_f(w_alu_a, w_alu_b, w_alu_ctrl);
    assign t_alu_res = alu_f(t_alu_a, t_alu_b, t_alu_ctrl);

    module_alu_arbiter #(.ALU_LAT(1), .CNT_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(m_rdy0), .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_op_i(req0_op),
        .req1_valid_i(req1_valid), .req1_ready_o(m_rdy1), .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_op_i(req1_op),
        .alu_a_o(m_alu_a), .alu_b_o(m_alu_b), .alu_ctrl_o(m_alu_ctrl), .alu_result_i(m_alu_res),
        .rsp_valid_o(m_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(m_rsp_id), .rsp_result_o(m_rsp_res),
        .busy_o(m_busy), .op_cnt_o(m_cnt)
    );

    module_alu_arbiter #(.ALU_LAT(1), .CNT_W(4)) dut_w (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(w_rdy0), .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_op_i(req0_op),
        .req1_valid_i(req1_valid), .req1_ready_o(w_rdy1), .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_op_i(req1_op),
        .alu_a_o(w_alu_a), .alu_b_o(w_alu_b), .alu_ctrl_o(w_alu_ctrl), .alu_result_i(w_alu_res),
        .rsp_valid_o(w_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(w_rsp_id), .rsp_result_o(w_rsp_res),
        .busy_o(w_busy), .op_cnt_o(w_cnt)
    );

    module_alu_arbiter #(.ALU_LAT(3), .CNT_W(16)) dut_3 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(t_req0_valid), .req0_ready_o(t_rdy0), .req0_a_i(t_req0_a), .req0_b_i(t_req0_b), .req0_op_i(t_req0_op),
        .req1_valid_i(t_req1_valid), .req1_ready_o(t_rdy1), .req1_a_i(t_req1_a), .req1_b_i(t_req1_b), .req1_op_i(t_req1_op),
        .alu_a_o(t_alu_a), .alu_b_o(t_alu_b), .alu_ctrl_o(t_alu_ctrl), .alu_result_i(t_alu_res),
        .rsp_valid_o(t_rsp_valid), .rsp_ready_i(t_rsp_ready), .rsp_id_o(t_rsp_id), .rsp_result_o(t_rsp_res),
        .busy_o(t_busy), .op_cnt_o(t_cnt)
    );

    task automatic apply_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'h0;
        req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'h0;
        t_req0_valid = 1'b0; t_req1_valid = 1'b0; t_rsp_ready = 1'b0;
        t_req0_a = 32'd0; t_req0_b = 32'd0; t_req0_op = 4'h0;
        t_req1_a = 32'd0; t_req1_b = 32'd0; t_req1_op = 4'h0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if (m_rdy0 !== 1'b0 || m_rdy1 !== 1'b0 || m_rsp_valid !== 1'b0 || m_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy0=%b rdy1=%b rsp_valid=%b busy=%b, want all 0", m_rdy0, m_rdy1, m_rsp_valid, m_busy);
        end
        n_chk++;
        if (m_alu_a !== 32'd0 || m_alu_b !== 32'd0 || m_alu_ctrl !== 4'h0 || m_rsp_res !== 32'd0 || m_rsp_id !== 1'b0 || m_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: alu_a=%0h alu_b=%0h ctrl=%0h res=%0h id=%b cnt=%0d, want all 0",
                     m_alu_a, m_alu_b, m_alu_ctrl, m_rsp_res, m_rsp_id, m_cnt);
        end
        req0_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'h0; rsp_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (m_rdy0 !== 1'b1 || m_rdy1 !== 1'b0) begin
            n_fail++; $display("FAIL basic_ready: rdy0=%b rdy1=%b, want 1 0", m_rdy0, m_rdy1);
        end
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (m_rsp_valid !== 1'b0 || m_busy !== 1'b1 || m_alu_a !== 32'd5 || m_alu_b !== 32'd3 || m_rdy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_exec: rsp_valid=%b busy=%b a=%0d b=%0d rdy0=%b, want 0 1 5 3 0", m_rsp_valid, m_busy, m_alu_a, m_alu_b, m_rdy0);
        end
        @(negedge clk);
        n_chk++;
        if (m_rsp_valid !== 1'b1 || m_rsp_res !== 32'd8 || m_rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_rsp: valid=%b res=%0d id=%b, want 1 8 0", m_rsp_valid, m_rsp_res, m_rsp_id);
        end
        @(posedge clk); #1;
        n_chk++;
        if (m_cnt !== 16'd1 || m_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_cnt: cnt=%0d rsp_valid=%b, want 1 0", m_cnt, m_rsp_valid);
        end
    endtask

    task automatic test_tie();
        int to;
        logic exp_id;
        apply_reset();
        req0_a = 32'd10; req0_b = 32'd1; req0_op = 4'h1;
        req1_a = 32'd6;  req1_b = 32'd3; req1_op = 4'h2;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            to = 0;
            @(negedge clk);
            while (!(m_rdy0 || m_rdy1) && to < 10) begin @(negedge clk); to++; end
            n_chk++;
            if (m_rdy0 !== ~exp_id || m_rdy1 !== exp_id) begin
                n_fail++; $display("FAIL tie_grant%0d: rdy0=%b rdy1=%b, want grant %0d", k, m_rdy0, m_rdy1, exp_id);
            end
            to = 0;
            @(negedge clk);
            while (!m_rsp_valid && to < 10) begin @(negedge clk); to++; end
            n_chk++;
            if (m_rsp_valid !== 1'b1 || m_rsp_id !== exp_id || m_rsp_res !== (exp_id ? 32'd2 : 32'd9)) begin
                n_fail++;
                $display("FAIL tie_rsp%0d: valid=%b id=%b res=%0d, want 1 %0d %0d", k, m_rsp_valid, m_rsp_id, m_rsp_res, exp_id, exp_id ? 2 : 9);
            end
            if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        @(posedge clk); #1;
        n_chk++;
        if (m_cnt !== 16'd4) begin n_fail++; $display("FAIL tie_cnt: cnt=%0d, want 4", m_cnt); end
    endtask

    task automatic test_backpressure();
        int to;
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd2; req1_op = 4'h1; rsp_ready = 1'b0;
        @(negedge clk);
        n_chk++;
        if (m_rdy1 !== 1'b1 || m_rdy0 !== 1'b0) begin
            n_fail++; $display("FAIL bp_grant: rdy0=%b rdy1=%b, want 0 1", m_rdy0, m_rdy1);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_op = 4'h0;
        to = 0;
        @(negedge clk);
        while (!m_rsp_valid && to < 10) begin @(negedge clk); to++; end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (m_rsp_valid !== 1'b1 || m_rsp_id !== 1'b1 || m_rsp_res !== 32'd5 || m_rdy0 !== 1'b0 || m_rdy1 !== 1'b0 || m_cnt !== 16'd4) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b id=%b res=%0d rdy0=%b rdy1=%b cnt=%0d, want 1 1 5 0 0 4",
                         i, m_rsp_valid, m_rsp_id, m_rsp_res, m_rdy0, m_rdy1, m_cnt);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (m_cnt !== 16'd5 || m_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: cnt=%0d rsp_valid=%b, want 5 0", m_cnt, m_rsp_valid);
        end
        @(negedge clk);
        n_chk++;
        if (m_rdy0 !== 1'b1) begin n_fail++; $display("FAIL bp_queued: rdy0=%b, want 1", m_rdy0); end
        @(posedge clk); #1 req0_valid = 1'b0;
        to = 0;
        @(negedge clk);
        while (!m_rsp_valid && to < 10) begin @(negedge clk); to++; end
        n_chk++;
        if (m_rsp_valid !== 1'b1 || m_rsp_id !== 1'b0 || m_rsp_res !== 32'd8) begin
            n_fail++; $display("FAIL bp_next: valid=%b id=%b res=%0d, want 1 0 8", m_rsp_valid, m_rsp_id, m_rsp_res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lat3();
        t_req1_valid = 1'b1; t_req1_a = 32'd9; t_req1_b = 32'd5; t_req1_op = 4'hF; t_rsp_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (t_rdy1 !== 1'b1 || t_rdy0 !== 1'b0) begin
            n_fail++; $display("FAIL lat3_grant: rdy0=%b rdy1=%b, want 0 1", t_rdy0, t_rdy1);
        end
        @(posedge clk); #1 t_req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (t_alu_ctrl !== 4'hF || t_alu_a !== 32'd9 || t_rsp_valid !== 1'b0 || t_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL lat3_hold%0d: ctrl=%0h a=%0d rsp_valid=%b busy=%b, want f 9 0 1", i, t_alu_ctrl, t_alu_a, t_rsp_valid, t_busy);
            end
        end
        @(negedge clk);
        n_chk++;
        if (t_rsp_valid !== 1'b1 || t_rsp_id !== 1'b1 || t_rsp_res !== 32'd12) begin
            n_fail++; $display("FAIL lat3_rsp: valid=%b id=%b res=%0d, want 1 1 12", t_rsp_valid, t_rsp_id, t_rsp_res);
        end
        @(posedge clk); #1;
        n_chk++;
        if (t_cnt !== 16'd1) begin n_fail++; $display("FAIL lat3_cnt: cnt=%0d, want 1", t_cnt); end
    endtask

    task automatic test_reset_exec();
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 4'h0; rsp_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (m_rdy1 !== 1'b1) begin n_fail++; $display("FAIL rx_grant: rdy1=%b, want 1", m_rdy1); end
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (m_busy !== 1'b0 || m_rsp_valid !== 1'b0 || m_alu_a !== 32'd0 || m_alu_ctrl !== 4'h0 || m_rsp_res !== 32'd0 || m_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rx_async: busy=%b rsp_valid=%b a=%0d ctrl=%0h res=%0d cnt=%0d, want all 0",
                     m_busy, m_rsp_valid, m_alu_a, m_alu_ctrl, m_rsp_res, m_cnt);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if (m_rsp_valid !== 1'b0 || m_busy !== 1'b0) begin
                n_fail++; $display("FAIL rx_no_rsp%0d: rsp_valid=%b busy=%b, want 0 0", i, m_rsp_valid, m_busy);
            end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_chk++;
        if (m_rdy0 !== 1'b1 || m_rdy1 !== 1'b0) begin
            n_fail++; $display("FAIL rx_tie: rdy0=%b rdy1=%b, want 1 0", m_rdy0, m_rdy1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_wrap();
        int to;
        apply_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            req0_valid = 1'b1; req0_a = bitsw_t'(k); req0_b = 32'd1; req0_op = 4'h0;
            to = 0;
            @(negedge clk);
            while (!m_rdy0 && to < 10) begin @(negedge clk); to++; end
            @(posedge clk); #1 req0_valid = 1'b0;
            to = 0;
            @(negedge clk);
            while (!m_rsp_valid && to < 10) begin @(negedge clk); to++; end
            n_chk++;
            if (m_rsp_valid !== 1'b1 || m_rsp_res !== bitsw_t'(k + 1)) begin
                n_fail++; $display("FAIL wrap_op%0d: valid=%b res=%0d, want 1 %0d", k, m_rsp_valid, m_rsp_res, k + 1);
            end
            @(posedge clk); #1;
        end
        n_chk++;
        if (w_cnt !== 4'd1 || m_cnt !== 16'd17) begin
            n_fail++; $display("FAIL wrap_cnt: cnt4=%0d cnt16=%0d, want 1 17", w_cnt, m_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_lat3();
        test_reset_exec();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
